// File: rtl/ramdisk_ptr_ctrl.sv
// Multi-channel RAM-disk pointer controller for the Apple II slot card.
// Auto-stepping SRAM address pointers behind a DEVSEL register window.
module ramdisk_ptr_ctrl #(
  parameter int         ADDR_W  = 24,
  parameter int         NCH     = 2,
  parameter logic [7:0] ID_BYTE = 8'hA5
) (
  input  logic              C7M,
  input  logic              RES,
  input  logic              PHI1,
  input  logic [3:0]        A,
  input  logic              nWE,
  input  logic              nDEVSEL,
  input  logic              nIOSEL,
  input  logic [7:0]        Din,
  output logic [7:0]        Dout,
  output logic              DOE,
  output logic [ADDR_W-1:0] RA,
  output logic              RAMCS,
  output logic              RDOE
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int NE = 1 << CW;
  localparam int NB = (ADDR_W + 7) / 8;
  localparam logic [31:0] FULL_MASK =
    32'((33'd1 << ADDR_W) - 33'd1);

  function automatic logic [31:0] pad(
    input logic [ADDR_W-1:0] v
  );
    logic [31:0] r;
    r = '0;
    r[ADDR_W-1:0] = v;
    return r;
  endfunction

  logic [2:0]        phi_q;
  logic              phi_fall;
  logic [2:0]        s;
  logic [2:0]        s_next;
  logic              csdben;
  logic              regen;
  logic [ADDR_W-1:0] ptr [NE];
  logic [NE-1:0]     dec;
  logic [NE-1:0]     stepen;
  logic [NE-1:0]     wrap;
  logic [CW-1:0]     sel;
  logic [CW-1:0]     sel_new;
  logic [2:0]        sel3;

  logic              pend;
  logic [1:0]        stg;
  logic [CW-1:0]     pend_ch;
  logic              pend_dec;
  logic              carry;

  logic [31:0]       full_mask;
  logic [31:0]       st_pad;
  logic [31:0]       st_res;
  logic [7:0]        st_byte;
  logic [7:0]        st_mask;
  logic [7:0]        st_new;
  logic              st_cin;
  logic              st_co;
  logic              st_fire;
  logic              st_last;

  logic [31:0]       wr_pad;
  logic [31:0]       sel_pad;
  logic [7:0]        rd;
  logic              commit;
  logic              acc;
  logic              wr;
  logic              data_acc;

  assign full_mask = FULL_MASK;
  assign phi_fall  = phi_q[2] & ~phi_q[1];
  assign commit    = (s == 3'd6);
  assign acc       = commit & regen & ~nDEVSEL;
  assign wr        = acc & ~nWE;
  assign data_acc  = acc & (A == 4'h4);
  assign sel_new   = CW'({29'd0, Din[2:0]} % 32'(NCH));
  assign sel3      = 3'(sel);

  // Bus phase counter: restart at PHI0 rise, saturate at 7.
  always_comb begin
    s_next = s;
    if (phi_fall)
      s_next = 3'd1;
    else if (s != 3'd0 && s != 3'd7)
      s_next = s + 3'd1;
  end

  // PHI1 synchroniser, phase register and data-bus enable window.
  always_ff @(posedge C7M or posedge RES) begin
    if (RES) begin
      phi_q  <= '0;
      s      <= '0;
      csdben <= 1'b0;
    end else begin
      phi_q  <= {phi_q[1:0], PHI1};
      s      <= s_next;
      csdben <= s_next[2];
    end
  end

  // One byte of the pending step, carry/borrow chained through stages.
  always_comb begin
    st_fire = pend && (s_next == ({1'b0, stg} + 3'd1));
    st_last = ({30'd0, stg} == 32'(NB - 1));
    st_pad  = pad(ptr[pend_ch]);
    st_byte = st_pad[{stg, 3'b000} +: 8];
    st_mask = full_mask[{stg, 3'b000} +: 8];
    st_cin  = (stg == 2'd0) ? 1'b1 : carry;
    if (pend_dec) begin
      st_new = (st_byte - {7'd0, st_cin}) & st_mask;
      st_co  = st_cin & ((st_byte & st_mask) == 8'd0);
    end else begin
      st_new = (st_byte + {7'd0, st_cin}) & st_mask;
      st_co  = st_cin & ((st_byte & st_mask) == st_mask);
    end
    st_res = st_pad;
    st_res[{stg, 3'b000} +: 8] = st_new;
  end

  // Byte-lane merge for pointer writes and register readback mux.
  always_comb begin
    wr_pad = pad(ptr[sel]);
    wr_pad[{A[1:0], 3'b000} +: 8] = Din;
    sel_pad = pad(ptr[sel]) | ~full_mask;
    rd = 8'h00;
    case (A)
      4'h0, 4'h1, 4'h2, 4'h3:
        rd = sel_pad[{A[1:0], 3'b000} +: 8];
      4'h5: rd = {2'b00, stepen[sel], dec[sel], 1'b0, sel3};
      4'h6: rd = {7'd0, wrap[sel]};
      4'hE: rd = ID_BYTE;
      default: rd = 8'h00;
    endcase
  end

  // Register file: S6 commits, staged steps, sticky wrap flags.
  always_ff @(posedge C7M or posedge RES) begin
    if (RES) begin
      for (int i = 0; i < NE; i++) ptr[i] <= '0;
      dec      <= '0;
      stepen   <= '0;
      wrap     <= '0;
      sel      <= '0;
      regen    <= 1'b0;
      pend     <= 1'b0;
      stg      <= '0;
      pend_ch  <= '0;
      pend_dec <= 1'b0;
      carry    <= 1'b0;
    end else begin
      if (st_fire) begin
        ptr[pend_ch] <= st_res[ADDR_W-1:0];
        carry        <= st_co;
        if (st_last) begin
          pend <= 1'b0;
          stg  <= '0;
          if (st_co) wrap[pend_ch] <= 1'b1;
        end else begin
          stg <= stg + 2'd1;
        end
      end
      if (commit && !nIOSEL) regen <= 1'b1;
      if (wr) begin
        case (A)
          4'h0, 4'h1, 4'h2, 4'h3: begin
            if ({30'd0, A[1:0]} < 32'(NB)) begin
              ptr[sel]  <= wr_pad[ADDR_W-1:0];
              wrap[sel] <= 1'b0;
            end
          end
          4'h5: begin
            sel             <= sel_new;
            dec[sel_new]    <= Din[4];
            stepen[sel_new] <= Din[5];
          end
          default: ;
        endcase
      end
      if (data_acc && stepen[sel]) begin
        pend     <= 1'b1;
        stg      <= '0;
        pend_ch  <= sel;
        pend_dec <= dec[sel];
      end
    end
  end

  assign RA    = ptr[sel];
  assign Dout  = regen ? rd : 8'h00;
  assign DOE   = csdben & nWE & ~nDEVSEL & regen;
  assign RAMCS = csdben & regen & ~nDEVSEL & (A == 4'h4);
  assign RDOE  = RAMCS & ~nWE;

endmodule

// File: tb/tb_ramdisk_ptr_ctrl.sv
// Bench for ramdisk_ptr_ctrl: 24-bit and 20-bit instances side by side,
// checked against an access-level model of the register map.
module tb_ramdisk_ptr_ctrl;

  localparam int NCH = 2;

  logic        clk = 1'b0;
  logic        RES;
  logic        PHI1;
  logic [3:0]  A;
  logic        nWE;
  logic        nDEVSEL;
  logic        nIOSEL;
  logic [7:0]  Din;

  logic [7:0]  dout24, dout20;
  logic        doe24, doe20;
  logic        cs24, cs20;
  logic        rdoe24, rdoe20;
  logic [23:0] ra24;
  logic [19:0] ra20;

  int n_cmp = 0;
  int n_bad = 0;

  longint unsigned mptr  [2][NCH];
  bit              mwrap [2][NCH];
  bit              mdec  [NCH];
  bit              mstep [NCH];
  int              msel;
  bit              mregen;
  bit              dead;

  ramdisk_ptr_ctrl #(.ADDR_W(24), .NCH(NCH), .ID_BYTE(8'hA5)) dut (
    .C7M(clk), .RES(RES), .PHI1(PHI1), .A(A), .nWE(nWE),
    .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL), .Din(Din),
    .Dout(dout24), .DOE(doe24), .RA(ra24),
    .RAMCS(cs24), .RDOE(rdoe24)
  );

  ramdisk_ptr_ctrl #(.ADDR_W(20), .NCH(NCH), .ID_BYTE(8'hA5)) dut20 (
    .C7M(clk), .RES(RES), .PHI1(PHI1), .A(A), .nWE(nWE),
    .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL), .Din(Din),
    .Dout(dout20), .DOE(doe20), .RA(ra20),
    .RAMCS(cs20), .RDOE(rdoe20)
  );

  always #5 clk = ~clk;

  function automatic int wid(int m);
    return (m == 0) ? 24 : 20;
  endfunction

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mread(int m, int a);
    longint unsigned full;
    full = mptr[m][msel] | ~((64'd1 << wid(m)) - 64'd1);
    case (a)
      0, 1, 2, 3: return 8'((full >> (8 * a)) & 64'hFF);
      5: return 8'((int'(mstep[msel]) << 5) |
                   (int'(mdec[msel]) << 4) | msel);
      6: return {7'd0, mwrap[m][msel]};
      14: return 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  task automatic mreset();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < NCH; c++) begin
        mptr[m][c]  = 0;
        mwrap[m][c] = 0;
      end
    for (int c = 0; c < NCH; c++) begin
      mdec[c]  = 0;
      mstep[c] = 0;
    end
    msel   = 0;
    mregen = 0;
    dead   = 1;
  endtask

  task automatic mstep_ptr(int m);
    longint unsigned mx;
    mx = (64'd1 << wid(m)) - 64'd1;
    if (!mdec[msel]) begin
      if (mptr[m][msel] == mx) begin
        mptr[m][msel]  = 0;
        mwrap[m][msel] = 1;
      end else mptr[m][msel]++;
    end else begin
      if (mptr[m][msel] == 0) begin
        mptr[m][msel]  = mx;
        mwrap[m][msel] = 1;
      end else mptr[m][msel]--;
    end
  endtask

  task automatic mapply(int a, bit nwe, logic [7:0] d,
                        bit ndev, bit nios);
    longint unsigned mk;
    if (dead) begin
      dead = 0;
      return;
    end
    if (mregen && !ndev) begin
      if (!nwe) begin
        if (a <= 3) begin
          for (int m = 0; m < 2; m++)
            if (8 * a < wid(m)) begin
              mk = 64'hFF << (8 * a);
              mptr[m][msel] = ((mptr[m][msel] & ~mk) |
                (longint'(d) << (8 * a))) &
                ((64'd1 << wid(m)) - 64'd1);
              mwrap[m][msel] = 0;
            end
        end else if (a == 5) begin
          msel        = int'(d[2:0]) % NCH;
          mdec[msel]  = d[4];
          mstep[msel] = d[5];
        end
      end
      if (a == 4 && mstep[msel])
        for (int m = 0; m < 2; m++) mstep_ptr(m);
    end
    if (!nios) mregen = 1;
  endtask

  // Outputs are meaningful here: S4 window, prior steps complete.
  task automatic compare();
    bit e_doe, e_cs, e_rdoe;
    e_doe  = mregen & !nDEVSEL & nWE;
    e_cs   = mregen & !nDEVSEL & (A == 4'h4);
    e_rdoe = e_cs & !nWE;
    chk("ra24", 64'(ra24), mptr[0][msel]);
    chk("ra20", 64'(ra20), mptr[1][msel]);
    chk("doe24", 64'(doe24), 64'(e_doe));
    chk("doe20", 64'(doe20), 64'(e_doe));
    chk("ramcs24", 64'(cs24), 64'(e_cs));
    chk("ramcs20", 64'(cs20), 64'(e_cs));
    chk("rdoe24", 64'(rdoe24), 64'(e_rdoe));
    chk("rdoe20", 64'(rdoe20), 64'(e_rdoe));
    if (e_doe && A != 4'h4) begin
      chk("dout24", 64'(dout24), 64'(mread(0, int'(A))));
      chk("dout20", 64'(dout20), 64'(mread(1, int'(A))));
    end
  endtask

  task automatic slot(int a, bit nwe, logic [7:0] d,
                      bit ndev, bit nios, bit pulse);
    A       = 4'(a);
    nWE     = nwe;
    Din     = d;
    nDEVSEL = ndev;
    nIOSEL  = nios;
    PHI1    = 1'b1;
    repeat (2) @(negedge clk);
    compare();
    repeat (2) @(negedge clk);
    PHI1 = 1'b0;
    mapply(a, nwe, d, ndev, nios);
    repeat (3) @(negedge clk);
    if (pulse) begin
      RES = 1'b1;
      #1;
      chk("rst_ra24", 64'(ra24), 64'h0);
      chk("rst_ra20", 64'(ra20), 64'h0);
      chk("rst_doe", 64'(doe24), 64'h0);
      chk("rst_ramcs", 64'(cs24), 64'h0);
      chk("rst_dout", 64'(dout24), 64'h0);
      mreset();
    end
    @(negedge clk);
    RES = 1'b0;
  endtask

  task automatic idle();
    slot(0, 1, 8'h00, 1, 1, 0);
  endtask
  task automatic ios();
    slot(0, 1, 8'h00, 1, 0, 0);
  endtask
  task automatic wr(int a, logic [7:0] d);
    slot(a, 0, d, 0, 1, 0);
  endtask
  task automatic rd(int a);
    slot(a, 1, 8'h00, 0, 1, 0);
  endtask

  initial begin
    RES     = 1'b1;
    PHI1    = 1'b0;
    A       = 4'h0;
    nWE     = 1'b1;
    nDEVSEL = 1'b1;
    nIOSEL  = 1'b1;
    Din     = 8'h00;
    mreset();
    repeat (3) @(negedge clk);
    chk("init_ra", 64'(ra24), 64'h0);
    chk("init_dout", 64'(dout24), 64'h0);
    chk("init_doe", 64'(doe24), 64'h0);
    chk("init_ramcs", 64'(cs24), 64'h0);
    RES = 1'b0;

    idle();
    wr(0, 8'h12);
    ios();
    rd(0);
    chk("no_regen_wr", 64'(dout24), 64'h00);
    wr(0, 8'h12);
    wr(1, 8'h34);
    wr(2, 8'h56);
    rd(0);
    chk("ra_563412", 64'(ra24), 64'h563412);
    chk("rd0_12", 64'(dout24), 64'h12);
    rd(1);
    rd(2);
    chk("rd2_56", 64'(dout24), 64'h56);
    chk("rd2_w20", 64'(dout20), 64'hF6);
    chk("ra20_63412", 64'(ra20), 64'h63412);
    rd(3);
    chk("rd3_ff", 64'(dout24), 64'hFF);
    rd(14);
    chk("id_a5", 64'(dout24), 64'hA5);
    rd(7);

    wr(0, 8'hFF);
    wr(1, 8'hFF);
    wr(2, 8'h00);
    wr(5, 8'h20);
    rd(5);
    chk("ctrl_20", 64'(dout24), 64'h20);
    repeat (4) rd(4);
    rd(6);
    chk("inc_010003", 64'(ra24), 64'h010003);
    chk("inc_nowrap", 64'(dout24), 64'h00);

    wr(0, 8'hFF);
    wr(1, 8'hFF);
    wr(2, 8'hFF);
    slot(4, 0, 8'hAA, 0, 1, 0);
    rd(6);
    chk("wrap_ra0", 64'(ra24), 64'h0);
    chk("wrap_set", 64'(dout24), 64'h01);
    wr(0, 8'h00);
    rd(6);
    chk("wrap_clr", 64'(dout24), 64'h00);

    wr(5, 8'h30);
    rd(5);
    chk("ctrl_30", 64'(dout24), 64'h30);
    wr(0, 8'h01);
    wr(1, 8'h00);
    wr(2, 8'h00);
    rd(4);
    rd(4);
    rd(6);
    chk("dec_ffffff", 64'(ra24), 64'hFFFFFF);
    chk("dec_wrap", 64'(dout24), 64'h01);

    wr(5, 8'h20);
    wr(0, 8'h00);
    wr(1, 8'h01);
    wr(2, 8'h00);
    wr(5, 8'h21);
    wr(0, 8'h00);
    wr(1, 8'h20);
    wr(2, 8'h00);
    repeat (2) begin
      wr(5, 8'h20);
      rd(4);
      wr(5, 8'h21);
      rd(4);
    end
    rd(0);
    chk("ch1_002002", 64'(ra24), 64'h002002);
    chk("ch1_b0", 64'(dout24), 64'h02);
    wr(5, 8'h20);
    rd(1);
    chk("ch0_000102", 64'(ra24), 64'h000102);
    chk("ch0_b1", 64'(dout24), 64'h01);
    wr(5, 8'h03);
    rd(5);
    chk("sel_mod", 64'(dout24), 64'h01);

    wr(5, 8'h20);
    wr(0, 8'hFF);
    wr(1, 8'h01);
    wr(2, 8'h00);
    slot(4, 1, 8'h00, 0, 1, 1);
    idle();
    wr(0, 8'h12);
    ios();
    rd(0);
    chk("post_rst_b0", 64'(dout24), 64'h00);
    chk("post_rst_ra", 64'(ra24), 64'h0);
    rd(5);
    chk("post_rst_ctrl", 64'(dout24), 64'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
